sr_lock_arbiter: RTL
====================

// Module: sr_lock_arbiter
// PURPOSE
//  Round-robin mutex arbiter sharing one set/reset lock flag among NUM_REQ requesters.
//  The lock flag is SET on grant and RESET on release or watchdog expiry.
//  A hold watchdog forces release when an owner holds the lock too long.
//  Sits between requester FSMs and any shared single-owner resource.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..16)
//  HOLD_MAX  255  max cycles an owner may hold the lock; 0 = watchdog disabled
//  OWNER_W   $clog2(NUM_REQ)  derived; width of OWNER
// PORTS
//  CLK      in   1        clock, all logic on rising edge
//  RESET    in   1        synchronous, active-high
//  REQ      in   NUM_REQ  per-requester lock request, level
//  REL      in   NUM_REQ  per-requester release strobe, 1-cycle pulse
//  GNT      out  NUM_REQ  one-hot grant, registered; all-zero when unlocked
//  LOCKED   out  1        lock flag (= |GNT)
//  OWNER    out  OWNER_W  index of current owner; holds last owner when unlocked
//  TIMEOUT  out  1        1-cycle pulse when the watchdog forces a release
// BEHAVIOUR
//  Reset: GNT=0, LOCKED=0, OWNER=0, TIMEOUT=0, state IDLE, rr pointer=0, hold count=0.
//  States: IDLE -> HELD -> IDLE; HELD -> RECOVER -> IDLE on watchdog expiry.
//  IDLE: if |REQ, pick first set REQ at or after ptr (wrapping at NUM_REQ-1 -> 0).
//   GNT[i]=1, LOCKED=1, OWNER=i on the next edge (1-cycle latency); enter HELD.
//   No REQ: stay IDLE, outputs unchanged.
//  HELD: REQ is don't-care for the owner; other REQs wait, no preemption.
//   REL[OWNER]=1: lock reset, GNT=0 next edge, ptr=OWNER+1 (mod NUM_REQ), go IDLE.
//   REL from a non-owner: ignored, no effect.
//   Hold count increments each HELD cycle from 1 on the grant cycle.
//   Count reaches HOLD_MAX with no owner REL: TIMEOUT=1 for one cycle, GNT=0, go RECOVER,
//   ptr=OWNER+1.
//   Owner REL in the same cycle as expiry: REL wins, no TIMEOUT.
//  RECOVER: one dead cycle with GNT=0, then IDLE. REL during RECOVER is ignored.
//  After a release, the next grant is at the earliest 1 cycle later (IDLE cycle).
//  Back-to-back re-grant of the same requester happens only if no other REQ is set.
//  RESET mid-HELD: lock cleared immediately; no TIMEOUT pulse; ptr=0.
//  HOLD_MAX=0: hold counter inactive; TIMEOUT never asserts.
//  Hold counter width is $clog2(HOLD_MAX+1) and it saturates, never wrapping.
//  Invariant: GNT is one-hot or zero; LOCKED == |GNT.
// STRUCTURE
//  Shared package sr_lock_pkg:
//   - state enum {IDLE, HELD, RECOVER}
//   - function rr_pick(req, ptr) returning the index and a valid bit
//  Sub-module sr_flag_cell: 1-bit set/reset flag, SET priority, sync reset.
//   Holds the lock flag: SET=grant, RESET=release|timeout.
//  The top holds the FSM, rr pointer, hold counter and one-hot grant register.
// TESTING
//  1. Basic grant: REQ=0001 -> GNT=0001, OWNER=0 one cycle later; REL=0001 -> GNT=0000 next cycle.
//  2. Round robin: REQ=1111 held; each owner RELs after 2 cycles -> grant order 0,1,2,3,0.
//  3. Foreign release: owner 2, REL=0001 pulsed -> GNT stays 0100, LOCKED stays 1.
//  4. Watchdog: HOLD_MAX=8, owner 1 never RELs -> TIMEOUT pulse exactly 8 cycles after grant.
//     GNT=0 for one RECOVER cycle, then the next REQ is granted starting from index 2.
//  5. Race: owner REL in the same cycle as HOLD_MAX -> no TIMEOUT, normal IDLE.
//  6. RESET asserted while HELD (owner 3) -> next edge all outputs 0; REQ=1000 regranted after.
//  Assertions on all tests: GNT one-hot-or-zero; LOCKED == |GNT; TIMEOUT never 2 cycles wide.

Source files
------------

// File: rtl/sr_lock_pkg.sv
// Shared types and the round-robin pick helper for the lock arbiter.
// rr_pick works on a 16-bit request vector so any requester count up to 16 can use it.
package sr_lock_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned K_W     = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        RECOVER = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping at num_req-1 back to 0.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        num_req
    );
        rr_pick_t   pick;
        logic [K_W-1:0] k;
        pick = '0;
        for (int unsigned off = 0; off < MAX_REQ; off++) begin
            k = {1'b0, ptr} + K_W'(off);
            if (k >= K_W'(num_req)) begin
                k = k - K_W'(num_req);
            end
            if ((off < num_req) && !pick.valid && req[k[IDX_W-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = k[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// Single set/reset flag with set priority and synchronous reset.
// Holds the arbiter's lock flag: set on grant, cleared on release or watchdog expiry.
module sr_flag_cell (
    input  logic CLK,
    input  logic RESET,
    input  logic set,
    input  logic clr,
    output logic flag
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flag <= 1'b0;
        end else if (set) begin
            flag <= 1'b1;
        end else if (clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_lock_arbiter.sv
// Round-robin mutex arbiter sharing one lock flag among NUM_REQ requesters,
// with a hold watchdog that forces the owner off after HOLD_MAX cycles.
//
// state   | meaning
// IDLE    | unlocked, grant the next requester from the rr pointer
// HELD    | one owner holds the lock; wait for its REL or watchdog expiry
// RECOVER | one dead cycle after a forced release
module sr_lock_arbiter
    import sr_lock_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned HOLD_MAX = 255,
    parameter int unsigned OWNER_W  = $clog2(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] REL,
    output logic [NUM_REQ-1:0] GNT,
    output logic               LOCKED,
    output logic [OWNER_W-1:0] OWNER,
    output logic               TIMEOUT
);

    localparam int unsigned CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_HELD    = HELD;
    localparam logic [1:0] S_RECOVER = RECOVER;

    logic [1:0]         state;
    logic [OWNER_W-1:0] ptr;
    logic [OWNER_W-1:0] owner_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [CNT_W-1:0]   hold_cnt;
    logic               timeout_q;

    rr_pick_t           pick;
    logic [OWNER_W-1:0] pick_owner;
    logic [OWNER_W-1:0] owner_inc;
    logic               rel_owner;
    logic               expire;
    logic               grant_now;
    logic               drop_now;
    logic               unused_pick_idx;

    always_comb begin
        pick       = rr_pick(MAX_REQ'(REQ), IDX_W'(ptr), NUM_REQ);
        pick_owner = pick.idx[OWNER_W-1:0];
        owner_inc  = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        rel_owner  = REL[owner_q];
        expire     = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX));
        grant_now  = (state == S_IDLE) && pick.valid;
        drop_now   = (state == S_HELD) && (rel_owner || expire);
    end

    // Only the low OWNER_W bits of the pick index are meaningful here.
    assign unused_pick_idx = ^pick.idx;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick.valid) begin
                        gnt_q    <= NUM_REQ'(1) << pick_owner;
                        owner_q  <= pick_owner;
                        hold_cnt <= (HOLD_MAX != 0) ? CNT_W'(1) : '0;
                        state    <= S_HELD;
                    end
                end
                S_HELD: begin
                    // Owner release beats a watchdog expiry in the same cycle.
                    if (rel_owner) begin
                        gnt_q    <= '0;
                        ptr      <= owner_inc;
                        hold_cnt <= '0;
                        state    <= S_IDLE;
                    end else if (expire) begin
                        gnt_q     <= '0;
                        ptr       <= owner_inc;
                        hold_cnt  <= '0;
                        timeout_q <= 1'b1;
                        state     <= S_RECOVER;
                    end else if ((HOLD_MAX != 0) && (hold_cnt != CNT_W'(HOLD_MAX))) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_RECOVER: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    sr_flag_cell u_lock_flag (
        .CLK   (CLK),
        .RESET (RESET),
        .set   (grant_now),
        .clr   (drop_now),
        .flag  (LOCKED)
    );

    assign GNT     = gnt_q;
    assign OWNER   = owner_q;
    assign TIMEOUT = timeout_q;

endmodule
